obstacle_gen: RTL and testbench

//  Spawns, scrolls and retires ground obstacles for the stickman runner.

---
 rtl/obstacle_gen.sv | 203 ++++++++++++++++++++
 tb/tb_obstacle_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_gen.sv
// obstacle_gen: spawns, scrolls and retires ground obstacles for the runner; pixel query is combinational.
// Optional build macro OBSTACLE_GEN_SPEEDUP_EN: scroll speed ramps from SPEED to 2*SPEED.
module obstacle_gen #(
    parameter int unsigned N_OBS     = 4,
    parameter int unsigned OBS_W     = 12,
    parameter int unsigned SPAWN_X   = 639,
    parameter int unsigned SPEED     = 3,
    parameter int unsigned MIN_GAP   = 40,
    parameter int unsigned FIRST_GAP = 90,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned STICK_HW  = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       playing,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] GroundY,
    input  logic [9:0] StickmanX,
    input  logic [9:0] StickmanBottom,
    output logic       is_obstacle,
    output logic       obstacle_hit,
    output logic [3:0] obs_count
);

    localparam logic [9:0]  L_SPAWN = 10'(SPAWN_X);
    localparam logic [9:0]  L_SPEED = 10'(SPEED);
    localparam logic [9:0]  L_HW    = 10'(STICK_HW);
    localparam logic [10:0] L_WM1   = 11'(OBS_W - 1);
    localparam logic [7:0]  L_MGAP  = 8'(MIN_GAP);
    localparam logic [7:0]  L_FGAP  = 8'(FIRST_GAP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic             r_frame_q;
    logic [N_OBS-1:0] r_act;
    logic [9:0]       r_x [N_OBS];
    logic [5:0]       r_h [N_OBS];
    logic [15:0]      r_lfsr;
    logic [7:0]       r_gap;
    logic             r_hit;
    logic [3:0]       r_count;

    logic             w_tick;
    logic [9:0]       w_speed;
    logic [15:0]      w_lfsr_next;
    logic [N_OBS-1:0] w_nact;
    logic [9:0]       w_nx [N_OBS];
    logic [5:0]       w_nh [N_OBS];
    logic [7:0]       w_ngap;
    logic             w_placed;
    logic [9:0]       w_stick_l;
    logic [10:0]      w_stick_r;
    logic             w_hit_now;
    logic             w_pix;
    logic [3:0]       w_pop;

    always_ff @(posedge Clk) begin
        r_frame_q <= frame_clk;
    end

    assign w_tick      = frame_clk & ~r_frame_q;
    assign w_lfsr_next = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400) : {1'b0, r_lfsr[15:1]};

`ifdef OBSTACLE_GEN_SPEEDUP_EN
    logic [9:0] r_speed;
    logic [8:0] r_spd_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_speed   <= L_SPEED;
            r_spd_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (playing) begin
                r_speed   <= L_SPEED;
                r_spd_cnt <= '0;
            end
        end else if (playing && w_tick) begin
            r_spd_cnt <= r_spd_cnt + 9'd1;
            if (r_spd_cnt == '1 && r_speed < 10'(2 * SPEED))
                r_speed <= r_speed + 10'd1;
        end
    end

    assign w_speed = r_speed;
`else
    assign w_speed = L_SPEED;
`endif

    // Next-tick slot image: move/retire first, then spawn into the lowest free slot of that view.
    always_comb begin
        w_nact   = r_act;
        w_nx     = r_x;
        w_nh     = r_h;
        w_ngap   = r_gap;
        w_placed = 1'b0;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            if (r_act[i]) begin
                if (r_x[i] < w_speed)
                    w_nact[i] = 1'b0;
                else
                    w_nx[i] = r_x[i] - w_speed;
            end
        end
        if (r_gap != '0) begin
            w_ngap = r_gap - 8'd1;
        end else begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
                if (!w_nact[i] && !w_placed) begin
                    w_placed  = 1'b1;
                    w_nact[i] = 1'b1;
                    w_nx[i]   = L_SPAWN;
                    w_nh[i]   = 6'd16 + {1'b0, r_lfsr[1:0], 3'b000};
                    w_ngap    = L_MGAP + {2'b00, r_lfsr[7:2]};
                end
            end
        end
    end

    // Height test written as Bottom+h >= GroundY so a tall obstacle near row 0 cannot wrap.
    always_comb begin
        w_stick_l = (StickmanX >= L_HW) ? (StickmanX - L_HW) : '0;
        w_stick_r = {1'b0, StickmanX} + {1'b0, L_HW};
        w_hit_now = 1'b0;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            if (w_nact[i]
                && ({1'b0, w_nx[i]} <= w_stick_r)
                && (({1'b0, w_nx[i]} + L_WM1) >= {1'b0, w_stick_l})
                && (({1'b0, StickmanBottom} + {5'b0, w_nh[i]}) >= {1'b0, GroundY}))
                w_hit_now = 1'b1;
        end
    end

    always_comb begin
        w_pix = 1'b0;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            if (r_act[i]
                && (DrawX >= r_x[i])
                && ({1'b0, DrawX} <= ({1'b0, r_x[i]} + L_WM1))
                && (DrawY < GroundY)
                && (({1'b0, DrawY} + {5'b0, r_h[i]}) >= {1'b0, GroundY}))
                w_pix = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < N_OBS; i++)
            w_pop = w_pop + {3'b000, r_act[i]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_act   <= '0;
            for (int unsigned i = 0; i < N_OBS; i++) begin
                r_x[i] <= '0;
                r_h[i] <= '0;
            end
            r_lfsr  <= LFSR_SEED;
            r_gap   <= L_FGAP;
            r_hit   <= 1'b0;
            r_count <= '0;
        end else begin
            r_count <= w_pop;
            case (r_state)
                IDLE: begin
                    r_hit <= 1'b0;
                    if (playing) begin
                        r_state <= RUN;
                        r_act   <= '0;
                        for (int unsigned i = 0; i < N_OBS; i++) begin
                            r_x[i] <= '0;
                            r_h[i] <= '0;
                        end
                        r_gap <= L_FGAP;
                    end
                end
                RUN: begin
                    if (!playing) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        r_lfsr <= w_lfsr_next;
                        r_act  <= w_nact;
                        r_x    <= w_nx;
                        r_h    <= w_nh;
                        r_gap  <= w_ngap;
                        if (w_hit_now)
                            r_hit <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign is_obstacle  = w_pix;
    assign obstacle_hit = r_hit;
    assign obs_count    = r_count;

endmodule

// File: tb/tb_obstacle_gen.sv
// tb_obstacle_gen: scoreboard bench; stimulus queues expected outputs, a negedge monitor pops and compares.
// Two slots are used so the spawn path is guaranteed to find every slot busy before the first retires.
module tb_obstacle_gen;

    localparam int NS = 2;
    localparam int GY = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_clk;
    logic       playing;
    logic [9:0] DrawX, DrawY, GroundY, StickmanX, StickmanBottom;
    logic       is_obstacle, obstacle_hit;
    logic [3:0] obs_count;

    always #5 clk = ~clk;

    obstacle_gen #(.N_OBS(NS)) dut (
        .Clk            (clk),
        .Reset          (rst),
        .frame_clk      (frame_clk),
        .playing        (playing),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .GroundY        (GroundY),
        .StickmanX      (StickmanX),
        .StickmanBottom (StickmanBottom),
        .is_obstacle    (is_obstacle),
        .obstacle_hit   (obstacle_hit),
        .obs_count      (obs_count)
    );

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // kind 0: is_obstacle, 1: obstacle_hit, 2: obs_count
    always @(negedge clk) begin
        chk_t c;
        int   act;
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
                0:       act = int'(is_obstacle);
                1:       act = int'(obstacle_hit);
                default: act = int'(obs_count);
            endcase
            n_tests++;
            if (act != c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d (DrawX=%0d DrawY=%0d t=%0t)",
                         c.name, act, c.exp, DrawX, DrawY, $time);
            end
        end
    end

    logic        m_act [NS];
    int          m_x   [NS];
    int          m_h   [NS];
    logic [15:0] m_lfsr;
    int          m_gap;
    logic        m_hit;

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int m_pop();
        int n = 0;
        for (int i = 0; i < NS; i++) if (m_act[i]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 1'b0; m_x[i] = 0; m_h[i] = 0;
        end
        m_gap = 90;
        m_hit = 1'b0;
    endtask

    task automatic model_tick();
        logic [15:0] old;
        logic [1:0]  hsel;
        logic [5:0]  gsel;
        bit          placed;
        int          sl, sr;
        old    = m_lfsr;
        hsel   = old[1:0];
        gsel   = old[7:2];
        m_lfsr = galois(m_lfsr);
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (m_x[i] < 3) m_act[i] = 1'b0;
                else            m_x[i]   = m_x[i] - 3;
            end
        end
        if (m_gap > 0) begin
            m_gap--;
        end else begin
            placed = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (!m_act[i] && !placed) begin
                    placed   = 1'b1;
                    m_act[i] = 1'b1;
                    m_x[i]   = 639;
                    m_h[i]   = 16 + 8 * int'(hsel);
                    m_gap    = 40 + int'(gsel);
                end
            end
        end
        sl = int'(StickmanX) - 6;
        if (sl < 0) sl = 0;
        sr = int'(StickmanX) + 6;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i] && m_x[i] <= sr && m_x[i] + 11 >= sl && int'(StickmanBottom) >= GY - m_h[i])
                m_hit = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int kind, input int exp, input int dx, input int dy);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        q.push_back('{name, kind, exp});
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_clk = 1'b1;
        @(posedge clk); #1;
        frame_clk = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        model_tick();
        pulse_frame();
    endtask

    task automatic check_all();
        chk("obs_count", 2, m_pop(), 0, 0);
        chk("hit_flag", 1, int'(m_hit), 0, 0);
        chk("sky_empty", 0, 0, 5, 10);
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                chk("left_edge_in", 0, 1, m_x[i], GY - 1);
                if (m_x[i] > 0) chk("left_edge_out", 0, 0, m_x[i] - 1, GY - 1);
                chk("right_top_in", 0, 1, m_x[i] + 11, GY - m_h[i]);
                chk("right_out", 0, 0, m_x[i] + 12, GY - m_h[i]);
                chk("above_top", 0, 0, m_x[i], GY - m_h[i] - 1);
                chk("ground_row", 0, 0, m_x[i], GY);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int xs;
        rst = 1'b1; frame_clk = 1'b0; playing = 1'b0;
        DrawX = '0; DrawY = '0; GroundY = 10'(GY);
        StickmanX = 10'd300; StickmanBottom = 10'd0;
        m_lfsr = 16'hACE1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_all();

        // Frame ticks while idle must change nothing
        pulse_frame();
        check_all();

        playing = 1'b1;
        @(posedge clk); #1;
        model_clear();

        for (int k = 1; k <= 90; k++) tick();
        chk("no_spawn_before_91", 2, 0, 0, 0);
        tick();
        chk("first_spawn_count", 2, 1, 0, 0);
        chk("first_spawn_x639", 0, 1, 639, GY - 1);
        chk("first_spawn_x638", 0, 0, 638, GY - 1);
        check_all();

        // Scroll through full-slot blocking and the x=3 -> 0 -> retire sequence
        for (int k = 92; k <= 330; k++) begin
            tick();
            check_all();
        end

        s = -1;
        for (int n = 0; n < 300 && s < 0; n++) begin
            for (int i = 0; i < NS; i++)
                if (s < 0 && m_act[i] && m_x[i] > 30 && m_x[i] < 600) s = i;
            if (s < 0) begin
                tick();
                check_all();
            end
        end
        if (s < 0) begin
            n_tests++; n_fail++;
            $display("FAIL find_slot: no slot in hit window, expected one");
        end else begin
            StickmanX = 10'(m_x[s] - 3 - 7);
            StickmanBottom = 10'(GY - m_h[s]);
            tick();
            chk("hit_x_gap", 1, 0, 0, 0);
            StickmanX = 10'(m_x[s] - 3 - 6);
            StickmanBottom = 10'(GY - m_h[s] - 1);
            tick();
            chk("hit_too_low", 1, 0, 0, 0);
            StickmanX = 10'(m_x[s] - 3 - 6);
            StickmanBottom = 10'(GY - m_h[s]);
            tick();
            chk("hit_edge", 1, 1, 0, 0);
            StickmanX = 10'd300;
            StickmanBottom = 10'd0;
            tick();
            chk("hit_sticky", 1, 1, 0, 0);
            check_all();
        end

        // playing falls on the same cycle as a frame tick: no update, then frozen
        playing = 1'b0;
        pulse_frame();
        m_hit = 1'b0;
        chk("hit_cleared_idle", 1, 0, 0, 0);
        check_all();
        for (int k = 0; k < 10; k++) pulse_frame();
        check_all();

        xs = (s >= 0) ? m_x[s] : 0;
        playing = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_clear();
        chk("restart_count", 2, 0, 0, 0);
        chk("restart_cleared", 0, 0, xs, GY - 1);
        check_all();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all();
        end

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
